// File: rtl/rob_module_pkg.sv
// Shared types and default sizes for the reorder buffer.
package rob_module_pkg;

    localparam int GPR_SIZE         = 32;
    localparam int GPR_IDX_SIZE     = 5;
    localparam int DEF_ROB_DEPTH    = 8;
    localparam int DEF_ROB_IDX_SIZE = 3;

    // One in-flight instruction: allocation state, destination and captured result.
    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic                    writes_reg;
        logic [GPR_IDX_SIZE-1:0] dst;
        logic [GPR_SIZE-1:0]     value;
    } rob_entry_t;

endpackage

// File: rtl/rob_module.sv
// Reorder buffer: in-order allocation, out-of-order writeback, in-order retire
// into the regfile, plus two combinational operand lookup ports for dispatch.
module rob_module
    import rob_module_pkg::*;
#(
    parameter int ROB_DEPTH    = DEF_ROB_DEPTH,
    parameter int ROB_IDX_SIZE = DEF_ROB_IDX_SIZE
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic                    in_d_alloc_valid,
    input  logic                    in_d_writes_reg,
    input  logic [GPR_IDX_SIZE-1:0] in_d_dst_idx,
    output logic                    out_d_alloc_ready,
    output logic [ROB_IDX_SIZE-1:0] out_d_rob_idx,
    input  logic [ROB_IDX_SIZE-1:0] in_rd1_rob_idx,
    output logic                    out_rd1_done,
    output logic [GPR_SIZE-1:0]     out_rd1_value,
    input  logic [ROB_IDX_SIZE-1:0] in_rd2_rob_idx,
    output logic                    out_rd2_done,
    output logic [GPR_SIZE-1:0]     out_rd2_value,
    input  logic                    in_wb_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_wb_rob_idx,
    input  logic [GPR_SIZE-1:0]     in_wb_value,
    output logic                    out_rob_should_commit,
    output logic [GPR_SIZE-1:0]     out_rob_commit_value,
    output logic [GPR_IDX_SIZE-1:0] out_rob_regfile_index,
    output logic                    out_empty,
    output logic                    out_full
);

    localparam logic [ROB_IDX_SIZE:0] FULL_COUNT = (ROB_IDX_SIZE + 1)'(ROB_DEPTH);

    rob_entry_t              entries_q [ROB_DEPTH];
    rob_entry_t              entries_d [ROB_DEPTH];
    logic [ROB_IDX_SIZE-1:0] head_q, head_d;
    logic [ROB_IDX_SIZE-1:0] tail_q, tail_d;
    logic [ROB_IDX_SIZE:0]   count_q, count_d;
    rob_entry_t              head_entry;
    logic                    alloc;
    logic                    retire;

    // Operand lookup: a same-cycle writeback to a live entry bypasses the stored value.
    function automatic logic [GPR_SIZE:0] lookup(
        input rob_entry_t              entry,
        input logic [ROB_IDX_SIZE-1:0] idx,
        input logic                    wb_valid,
        input logic [ROB_IDX_SIZE-1:0] wb_idx,
        input logic [GPR_SIZE-1:0]     wb_value
    );
        logic [GPR_SIZE:0] res;
        res = '0;
        if (entry.valid && wb_valid && (wb_idx == idx)) begin
            res = {1'b1, wb_value};
        end else if (entry.valid && entry.done) begin
            res = {1'b1, entry.value};
        end
        return res;
    endfunction

    // Status, dispatch grant, retire decision, commit and lookup outputs.
    always_comb begin
        out_full              = (count_q == FULL_COUNT);
        out_empty             = (count_q == '0);
        out_d_alloc_ready     = !out_full;
        out_d_rob_idx         = tail_q;
        head_entry            = entries_q[head_q];
        alloc                 = in_d_alloc_valid && !out_full;
        retire                = head_entry.valid && head_entry.done && !in_flush;
        out_rob_should_commit = 1'b0;
        out_rob_commit_value  = '0;
        out_rob_regfile_index = '0;
        if (retire) begin
            out_rob_should_commit = head_entry.writes_reg;
            out_rob_commit_value  = head_entry.value;
            out_rob_regfile_index = head_entry.dst;
        end
        {out_rd1_done, out_rd1_value} = lookup(entries_q[in_rd1_rob_idx], in_rd1_rob_idx,
                                               in_wb_valid, in_wb_rob_idx, in_wb_value);
        {out_rd2_done, out_rd2_value} = lookup(entries_q[in_rd2_rob_idx], in_rd2_rob_idx,
                                               in_wb_valid, in_wb_rob_idx, in_wb_value);
    end

    // Next state: flush empties the buffer, otherwise apply writeback, retire and allocate.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (in_flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Writeback before retire so a result landing on the head is only seen next cycle.
            if (in_wb_valid && entries_q[in_wb_rob_idx].valid) begin
                entries_d[in_wb_rob_idx].done  = 1'b1;
                entries_d[in_wb_rob_idx].value = in_wb_value;
            end
            if (retire) begin
                entries_d[head_q].valid = 1'b0;
                head_d                  = head_q + 1'b1;
            end
            // Alloc is gated by full, so the slot at tail is never the one being retired.
            if (alloc) begin
                entries_d[tail_q].valid      = 1'b1;
                entries_d[tail_q].done       = 1'b0;
                entries_d[tail_q].writes_reg = in_d_writes_reg;
                entries_d[tail_q].dst        = in_d_dst_idx;
                entries_d[tail_q].value      = '0;
                tail_d                       = tail_q + 1'b1;
            end
            count_d = count_q + (ROB_IDX_SIZE + 1)'(alloc) - (ROB_IDX_SIZE + 1)'(retire);
        end
    end

    // State registers with synchronous reset clearing every entry and pointer.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_module.sv
// Self-checking bench for rob_module: queue-based reference model plus directed scenarios
// and a randomized phase.
module tb_rob_module;
    import rob_module_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        in_rst, in_flush;
    logic        in_d_alloc_valid, in_d_writes_reg;
    logic [4:0]  in_d_dst_idx;
    logic        out_d_alloc_ready;
    logic [2:0]  out_d_rob_idx;
    logic [2:0]  in_rd1_rob_idx, in_rd2_rob_idx;
    logic        out_rd1_done, out_rd2_done;
    logic [31:0] out_rd1_value, out_rd2_value;
    logic        in_wb_valid;
    logic [2:0]  in_wb_rob_idx;
    logic [31:0] in_wb_value;
    logic        out_rob_should_commit;
    logic [31:0] out_rob_commit_value;
    logic [4:0]  out_rob_regfile_index;
    logic        out_empty, out_full;

    rob_module dut (
        .in_clk(clk), .in_rst(in_rst), .in_flush(in_flush),
        .in_d_alloc_valid(in_d_alloc_valid), .in_d_writes_reg(in_d_writes_reg),
        .in_d_dst_idx(in_d_dst_idx), .out_d_alloc_ready(out_d_alloc_ready),
        .out_d_rob_idx(out_d_rob_idx),
        .in_rd1_rob_idx(in_rd1_rob_idx), .out_rd1_done(out_rd1_done), .out_rd1_value(out_rd1_value),
        .in_rd2_rob_idx(in_rd2_rob_idx), .out_rd2_done(out_rd2_done), .out_rd2_value(out_rd2_value),
        .in_wb_valid(in_wb_valid), .in_wb_rob_idx(in_wb_rob_idx), .in_wb_value(in_wb_value),
        .out_rob_should_commit(out_rob_should_commit), .out_rob_commit_value(out_rob_commit_value),
        .out_rob_regfile_index(out_rob_regfile_index),
        .out_empty(out_empty), .out_full(out_full)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions in program order; q[0] lives at slot m_head.
    typedef struct {
        bit          done;
        bit          wr;
        logic [4:0]  dst;
        logic [31:0] val;
    } rec_t;

    rec_t q[$];
    int   m_head = 0;

    function automatic int pos_of(input int idx);
        return (idx - m_head + 8) % 8;
    endfunction

    function automatic bit live(input int idx);
        return pos_of(idx) < q.size();
    endfunction

    task automatic expect_lookup(input int idx, output bit done, output logic [31:0] val);
        done = 1'b0;
        val  = '0;
        if (live(idx)) begin
            if (in_wb_valid && int'(in_wb_rob_idx) == idx) begin
                done = 1'b1;
                val  = in_wb_value;
            end else if (q[pos_of(idx)].done) begin
                done = 1'b1;
                val  = q[pos_of(idx)].val;
            end
        end
    endtask

    // Compare every DUT output against the model with the currently driven inputs.
    task automatic model_check();
        int          sz;
        bit          ret;
        bit          d;
        logic [31:0] v;
        sz  = q.size();
        ret = 1'b0;
        if (sz > 0) ret = q[0].done && !in_flush;
        chk("empty", 32'(out_empty), 32'(sz == 0));
        chk("full", 32'(out_full), 32'(sz == 8));
        chk("alloc_ready", 32'(out_d_alloc_ready), 32'(sz != 8));
        chk("rob_idx", 32'(out_d_rob_idx), 32'((m_head + sz) % 8));
        chk("should_commit", 32'(out_rob_should_commit), ret ? 32'(q[0].wr) : 32'd0);
        chk("commit_value", out_rob_commit_value, ret ? q[0].val : 32'd0);
        chk("commit_index", 32'(out_rob_regfile_index), ret ? 32'(q[0].dst) : 32'd0);
        expect_lookup(int'(in_rd1_rob_idx), d, v);
        chk("rd1_done", 32'(out_rd1_done), 32'(d));
        chk("rd1_value", out_rd1_value, v);
        expect_lookup(int'(in_rd2_rob_idx), d, v);
        chk("rd2_done", 32'(out_rd2_done), 32'(d));
        chk("rd2_value", out_rd2_value, v);
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_update();
        bit   ret;
        bit   al;
        rec_t r;
        if (in_rst || in_flush) begin
            q.delete();
            m_head = 0;
        end else begin
            ret = (q.size() > 0) && q[0].done;
            al  = in_d_alloc_valid && (q.size() < 8);
            if (in_wb_valid && live(int'(in_wb_rob_idx))) begin
                q[pos_of(int'(in_wb_rob_idx))].done = 1'b1;
                q[pos_of(int'(in_wb_rob_idx))].val  = in_wb_value;
            end
            if (ret) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % 8;
            end
            if (al) begin
                r.done = 1'b0;
                r.wr   = in_d_writes_reg;
                r.dst  = in_d_dst_idx;
                r.val  = '0;
                q.push_back(r);
            end
        end
    endtask

    task automatic idle();
        in_rst           = 1'b0;
        in_flush         = 1'b0;
        in_d_alloc_valid = 1'b0;
        in_d_writes_reg  = 1'b0;
        in_d_dst_idx     = '0;
        in_rd1_rob_idx   = '0;
        in_rd2_rob_idx   = '0;
        in_wb_valid      = 1'b0;
        in_wb_rob_idx    = '0;
        in_wb_value      = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        idle();
        in_rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        in_rst = 1'b0;
    endtask

    task automatic alloc1(input bit wr, input logic [4:0] dst);
        idle();
        in_d_alloc_valid = 1'b1;
        in_d_writes_reg  = wr;
        in_d_dst_idx     = dst;
        settle();
        adv();
    endtask

    task automatic wb1(input logic [2:0] idx, input logic [31:0] val);
        idle();
        in_wb_valid   = 1'b1;
        in_wb_rob_idx = idx;
        in_wb_value   = val;
        settle();
        adv();
    endtask

    initial begin
        idle();
        do_reset();

        // Reset state
        idle();
        settle();
        chk("lit_rst_empty", 32'(out_empty), 32'd1);
        chk("lit_rst_ready", 32'(out_d_alloc_ready), 32'd1);
        chk("lit_rst_idx", 32'(out_d_rob_idx), 32'd0);
        chk("lit_rst_commit", 32'(out_rob_should_commit), 32'd0);
        adv();

        // Single instruction, minimum latency
        alloc1(1'b1, 5'd5);
        wb1(3'd0, 32'd42);
        idle();
        settle();
        chk("lit_single_commit", 32'(out_rob_should_commit), 32'd1);
        chk("lit_single_index", 32'(out_rob_regfile_index), 32'd5);
        chk("lit_single_value", out_rob_commit_value, 32'd42);
        adv();
        settle();
        chk("lit_single_empty", 32'(out_empty), 32'd1);
        adv();

        // Out-of-order writeback, in-order commit
        do_reset();
        alloc1(1'b1, 5'd1);
        alloc1(1'b1, 5'd2);
        alloc1(1'b1, 5'd3);
        wb1(3'd2, 32'd30);
        wb1(3'd0, 32'd10);
        idle();
        in_wb_valid = 1'b1; in_wb_rob_idx = 3'd1; in_wb_value = 32'd20;
        settle();
        chk("lit_ooo_c0_idx", 32'(out_rob_regfile_index), 32'd1);
        chk("lit_ooo_c0_val", out_rob_commit_value, 32'd10);
        adv();
        idle();
        settle();
        chk("lit_ooo_c1_idx", 32'(out_rob_regfile_index), 32'd2);
        chk("lit_ooo_c1_val", out_rob_commit_value, 32'd20);
        adv();
        settle();
        chk("lit_ooo_c2_idx", 32'(out_rob_regfile_index), 32'd3);
        chk("lit_ooo_c2_val", out_rob_commit_value, 32'd30);
        adv();
        settle();
        chk("lit_ooo_empty", 32'(out_empty), 32'd1);
        adv();

        // Fill, overflow request, retire then alloc into wrapped slot
        do_reset();
        for (int i = 0; i < 8; i++) alloc1(1'b1, 5'(i + 8));
        idle();
        in_d_alloc_valid = 1'b1; in_d_writes_reg = 1'b1; in_d_dst_idx = 5'd31;
        in_wb_valid = 1'b1; in_wb_rob_idx = 3'd0; in_wb_value = 32'd99;
        settle();
        chk("lit_fill_full", 32'(out_full), 32'd1);
        chk("lit_fill_ready", 32'(out_d_alloc_ready), 32'd0);
        chk("lit_fill_idx", 32'(out_d_rob_idx), 32'd0);
        adv();
        idle();
        settle();
        chk("lit_fill_still_full", 32'(out_full), 32'd1);
        chk("lit_fill_commit_idx", 32'(out_rob_regfile_index), 32'd8);
        chk("lit_fill_commit_val", out_rob_commit_value, 32'd99);
        adv();
        idle();
        in_wb_valid = 1'b1; in_wb_rob_idx = 3'd1; in_wb_value = 32'd77;
        settle();
        chk("lit_fill_after_retire_full", 32'(out_full), 32'd0);
        adv();
        idle();
        in_d_alloc_valid = 1'b1; in_d_writes_reg = 1'b1; in_d_dst_idx = 5'd20;
        settle();
        chk("lit_wrap_idx", 32'(out_d_rob_idx), 32'd0);
        chk("lit_wrap_commit_idx", 32'(out_rob_regfile_index), 32'd9);
        adv();
        idle();
        settle();
        chk("lit_wrap_not_full", 32'(out_full), 32'd0);
        chk("lit_wrap_tail", 32'(out_d_rob_idx), 32'd1);
        adv();

        // Lookup bypass and non-writing retire
        do_reset();
        alloc1(1'b0, 5'd4);
        alloc1(1'b1, 5'd10);
        alloc1(1'b1, 5'd11);
        alloc1(1'b1, 5'd12);
        idle();
        in_wb_valid = 1'b1; in_wb_rob_idx = 3'd3; in_wb_value = 32'd7;
        in_rd1_rob_idx = 3'd3; in_rd2_rob_idx = 3'd0;
        settle();
        chk("lit_byp_done", 32'(out_rd1_done), 32'd1);
        chk("lit_byp_value", out_rd1_value, 32'd7);
        chk("lit_byp_rd2_done", 32'(out_rd2_done), 32'd0);
        adv();
        wb1(3'd0, 32'd11);
        idle();
        in_rd1_rob_idx = 3'd3;
        settle();
        chk("lit_nowr_commit", 32'(out_rob_should_commit), 32'd0);
        chk("lit_stored_rd1", out_rd1_value, 32'd7);
        adv();

        // Flush with live and done entries
        do_reset();
        for (int i = 1; i <= 4; i++) alloc1(1'b1, 5'(i));
        wb1(3'd2, 32'd5);
        wb1(3'd0, 32'd6);
        idle();
        in_flush = 1'b1;
        settle();
        chk("lit_flush_commit", 32'(out_rob_should_commit), 32'd0);
        adv();
        idle();
        in_wb_valid = 1'b1; in_wb_rob_idx = 3'd1; in_wb_value = 32'd55;
        in_rd1_rob_idx = 3'd1;
        settle();
        chk("lit_flush_empty", 32'(out_empty), 32'd1);
        chk("lit_flush_tail", 32'(out_d_rob_idx), 32'd0);
        chk("lit_flush_late_wb", 32'(out_rd1_done), 32'd0);
        adv();
        idle();
        in_rd1_rob_idx = 3'd1;
        settle();
        chk("lit_flush_dropped", 32'(out_rd1_done), 32'd0);
        adv();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            in_rst           = ($urandom % 300) == 0;
            in_flush         = ($urandom % 50) == 0;
            in_d_alloc_valid = ($urandom % 100) < 55;
            in_d_writes_reg  = ($urandom % 4) != 0;
            in_d_dst_idx     = 5'($urandom);
            in_wb_valid      = ($urandom % 100) < 60;
            in_wb_rob_idx    = 3'($urandom);
            in_wb_value      = $urandom;
            in_rd1_rob_idx   = 3'($urandom);
            in_rd2_rob_idx   = ($urandom % 2 == 0) ? in_wb_rob_idx : 3'($urandom);
            if (in_rst) begin
                adv();
            end else begin
                settle();
                adv();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
